// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle control FSM for the tiny CPU core. Fetches each
//            16-bit instruction as two bytes over an 8-bit memory handshake
//            port and holds it in the instruction register. It then
//            sequences decode, execute, memory access and write-back,
//            including conditional skip and jumps.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W          width of memory address / program counter
//   RESET_PC        PC value loaded on reset
// Optional build macro
//   CPU_SEQ_STEP_EN adds step_in / halted_out and a HALT state. The core
//                   halts before every fetch except the first one after reset.
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   mem_req/we/addr/wdata          memory request side (Moore outputs)
//   mem_rdata/mem_ack              memory response side
//   inst_out                       instruction register to the decoder
//   inst_type_in, cond_en_in,      decoded fields, valid from DECODE on
//   subtype_in
//   cond_flag_in                   ALU condition flag
//   data_addr_in, store_data_in    load/store operands from the register file
//   jump_target_in                 jump destination
//   reg_we_out, flag_we_out        one-cycle write strobes
//   wb_sel_out                     write-back source (0 ALU, 1 load, 2 imm)
//   load_data_out                  latched load byte
//   pc_out                         current program counter
// ============================================================================
module cpu_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CPU_SEQ_STEP_EN
    input  logic              step_in,
    output logic              halted_out,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       inst_out,
    input  logic [1:0]        inst_type_in,
    input  logic              cond_en_in,
    input  logic [3:0]        subtype_in,
    input  logic              cond_flag_in,
    input  logic [ADDR_W-1:0] data_addr_in,
    input  logic [7:0]        store_data_in,
    input  logic [ADDR_W-1:0] jump_target_in,
    output logic              reg_we_out,
    output logic              flag_we_out,
    output logic [1:0]        wb_sel_out,
    output logic [7:0]        load_data_out,
    output logic [ADDR_W-1:0] pc_out
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_HI = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EXEC     = 3'd4,
        ST_MEM      = 3'd5,
`ifdef CPU_SEQ_STEP_EN
        ST_WB       = 3'd6,
        ST_HALT     = 3'd7
`else
        ST_WB       = 3'd6
`endif
    } state_t;

    localparam logic [1:0] c_type_alu  = 2'd0;
    localparam logic [1:0] c_type_mem  = 2'd1;
    localparam logic [1:0] c_type_jump = 2'd2;
    localparam logic [1:0] c_type_imm  = 2'd3;

    localparam logic [1:0] c_wb_alu  = 2'd0;
    localparam logic [1:0] c_wb_load = 2'd1;
    localparam logic [1:0] c_wb_imm  = 2'd2;

    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_pc_two = ADDR_W'(2);

    // Where an instruction hands control back to the fetch stage. In the
    // stepping build every completed (or skipped) instruction parks in HALT.
`ifdef CPU_SEQ_STEP_EN
    localparam state_t c_st_resume = ST_HALT;
`else
    localparam state_t c_st_resume = ST_FETCH_HI;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [7:0]        r_load_data;
    logic [1:0]        r_wb_sel;
    logic              w_skip;
    logic              w_is_store;
    logic              w_unused;

    assign w_skip     = cond_en_in & ~cond_flag_in;
    assign w_is_store = subtype_in[0];
    assign w_unused   = ^subtype_in[3:1];

`ifdef CPU_SEQ_STEP_EN
    logic r_step_d;
    logic w_step_rise;

    assign w_step_rise = step_in & ~r_step_d;
    assign halted_out  = (r_state == ST_HALT);
`endif

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_pc;
        mem_wdata    = 8'h00;
        reg_we_out   = 1'b0;
        flag_we_out  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH_HI;
            end

            ST_FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) begin
                    w_state_next = ST_FETCH_LO;
                end
            end

            ST_FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = r_pc + c_pc_one;
                if (mem_ack) begin
                    w_state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (w_skip) begin
                    w_state_next = c_st_resume;
                end else if (inst_type_in == c_type_mem) begin
                    w_state_next = ST_MEM;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (inst_type_in)
                    c_type_alu: begin
                        reg_we_out  = 1'b1;
                        flag_we_out = 1'b1;
                    end
                    c_type_imm: begin
                        reg_we_out = 1'b1;
                    end
                    default: ;
                endcase
                w_state_next = c_st_resume;
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                mem_addr  = data_addr_in;
                mem_we    = w_is_store;
                mem_wdata = store_data_in;
                if (mem_ack) begin
                    w_state_next = w_is_store ? c_st_resume : ST_WB;
                end
            end

            ST_WB: begin
                reg_we_out   = 1'b1;
                w_state_next = c_st_resume;
            end

`ifdef CPU_SEQ_STEP_EN
            ST_HALT: begin
                if (w_step_rise) begin
                    w_state_next = ST_FETCH_HI;
                end
            end
`endif

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, PC, IR and write-back registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= 16'h0000;
            r_load_data <= 8'h00;
            r_wb_sel    <= c_wb_alu;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_FETCH_HI: begin
                    if (mem_ack) begin
                        r_ir[15:8] <= mem_rdata;
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ack) begin
                        r_ir[7:0] <= mem_rdata;
                        r_pc      <= r_pc + c_pc_two;
                    end
                end
                ST_DECODE: begin
                    // wb_sel is loaded on entry to the strobe cycle so it is
                    // already valid while reg_we_out is high and then holds.
                    if (!w_skip) begin
                        case (inst_type_in)
                            c_type_alu: r_wb_sel <= c_wb_alu;
                            c_type_imm: r_wb_sel <= c_wb_imm;
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (inst_type_in == c_type_jump) begin
                        r_pc <= jump_target_in;
                    end
                end
                ST_MEM: begin
                    if (mem_ack && !w_is_store) begin
                        r_load_data <= mem_rdata;
                        r_wb_sel    <= c_wb_load;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_SEQ_STEP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step_in;
        end
    end
`endif

    assign inst_out      = r_ir;
    assign pc_out        = r_pc;
    assign wb_sel_out    = r_wb_sel;
    assign load_data_out = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer. A byte-wide memory with
//            scripted wait states answers the handshake. A fake decoder maps
//            instruction bits onto the decoded inputs. An instruction-level
//            reference model predicts every bus transfer and strobe, together
//            with the cycle in which it occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int         ADDR_W = 8;
    localparam logic [7:0] RST_PC = 8'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [15:0] inst_out;
    logic [1:0]  inst_type_in = 2'd0;
    logic        cond_en_in = 1'b0;
    logic [3:0]  subtype_in = 4'd0;
    logic        cond_flag_in = 1'b0;
    logic [7:0]  data_addr_in = 8'h00;
    logic [7:0]  store_data_in = 8'h00;
    logic [7:0]  jump_target_in = 8'h00;
    logic        reg_we_out, flag_we_out;
    logic [1:0]  wb_sel_out;
    logic [7:0]  load_data_out, pc_out;
`ifdef CPU_SEQ_STEP_EN
    logic        step_in = 1'b0;
    logic        halted_out;
`endif

    always #5 clk = ~clk;

    cpu_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef CPU_SEQ_STEP_EN
        .step_in        (step_in),
        .halted_out     (halted_out),
`endif
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .inst_out       (inst_out),
        .inst_type_in   (inst_type_in),
        .cond_en_in     (cond_en_in),
        .subtype_in     (subtype_in),
        .cond_flag_in   (cond_flag_in),
        .data_addr_in   (data_addr_in),
        .store_data_in  (store_data_in),
        .jump_target_in (jump_target_in),
        .reg_we_out     (reg_we_out),
        .flag_we_out    (flag_we_out),
        .wb_sel_out     (wb_sel_out),
        .load_data_out  (load_data_out),
        .pc_out         (pc_out)
    );

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
    } tx_t;

    typedef struct {
        int         cyc;
        logic       reg_we;
        logic       flag_we;
        logic [1:0] wb_sel;
        logic [7:0] ld;
    } st_t;

    tx_t        act_tx[$], exp_tx[$];
    st_t        act_st[$], exp_st[$];
    logic [7:0] mem  [256];
    logic [7:0] mmem [256];
    int         waits[512];
    int         tn, wcnt, cyc, unstable;
    logic       pend;
    logic [7:0] p_addr, p_wdata;
    logic       p_we;
    int         exp_end;
    logic [7:0] exp_pc;
    int         n_tests = 0;
    int         n_fail = 0;

    // One clock: decoder update at negedge, then memory response/logging.
    task automatic cycle(input bit allow_ack);
        tx_t t;
        st_t s;
        @(negedge clk);
        cyc++;
        inst_type_in   = inst_out[15:14];
        cond_en_in     = inst_out[13];
        cond_flag_in   = inst_out[12];
        subtype_in     = inst_out[11:8];
        data_addr_in   = inst_out[7:0];
        store_data_in  = inst_out[7:0] ^ 8'h1A;
        jump_target_in = inst_out[7:0];
        #1;
        if (pend && mem_req === 1'b1) begin
            if (mem_addr !== p_addr || mem_we !== p_we || (p_we && mem_wdata !== p_wdata))
                unstable++;
        end
        if (mem_req === 1'b1) begin
            if (allow_ack && wcnt >= waits[tn]) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    mem_rdata = 8'($urandom);
                end else begin
                    mem_rdata = mem[mem_addr];
                end
                t.cyc = cyc; t.addr = mem_addr; t.we = mem_we; t.wdata = mem_wdata;
                act_tx.push_back(t);
                tn++; wcnt = 0; pend = 1'b0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 8'($urandom);
                wcnt++;
                pend = 1'b1; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            end
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
            pend      = 1'b0;
        end
        if (reg_we_out === 1'b1 || flag_we_out === 1'b1) begin
            s.cyc = cyc; s.reg_we = reg_we_out; s.flag_we = flag_we_out;
            s.wb_sel = wb_sel_out; s.ld = load_data_out;
            act_st.push_back(s);
        end
    endtask

    // Leaves the bench at the observation point of cycle 0 (IDLE, rst_n=1 set).
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cycle(1'b1);
        rst_n = 1'b1;
        cyc = 0; tn = 0; wcnt = 0; pend = 1'b0; unstable = 0;
        act_tx.delete();
        act_st.delete();
    endtask

    // Instruction-level reference: fetch two bytes, then apply the latency
    // table (ALU/IMM/JUMP 4, store 4, load 5, skip 3 cycles plus waits).
    task automatic model(input int n);
        logic [7:0]  pc, hi, lo, ld;
        logic [15:0] ins;
        int          s, d, t;
        tx_t         x;
        st_t         y;
        pc = RST_PC; s = 1; t = 0; ld = 8'h00;
        exp_tx.delete();
        exp_st.delete();
        for (int i = 0; i < n; i++) begin
            x.cyc = s + waits[t]; x.addr = pc; x.we = 1'b0; x.wdata = 8'h00;
            exp_tx.push_back(x); hi = mmem[pc]; t++;
            x.cyc = x.cyc + 1 + waits[t]; x.addr = pc + 8'd1;
            exp_tx.push_back(x); lo = mmem[pc + 8'd1]; t++;
            d = x.cyc + 1;
            ins = {hi, lo};
            pc = pc + 8'd2;
            if (ins[13] && !ins[12]) begin
                s = d + 1;
            end else begin
                case (ins[15:14])
                    2'd0: begin
                        y.cyc = d + 1; y.reg_we = 1'b1; y.flag_we = 1'b1; y.wb_sel = 2'd0; y.ld = ld;
                        exp_st.push_back(y); s = d + 2;
                    end
                    2'd3: begin
                        y.cyc = d + 1; y.reg_we = 1'b1; y.flag_we = 1'b0; y.wb_sel = 2'd2; y.ld = ld;
                        exp_st.push_back(y); s = d + 2;
                    end
                    2'd2: begin
                        pc = lo; s = d + 2;
                    end
                    default: begin
                        x.cyc = d + 1 + waits[t]; t++;
                        x.addr = lo; x.we = ins[8]; x.wdata = lo ^ 8'h1A;
                        exp_tx.push_back(x);
                        if (ins[8]) begin
                            mmem[lo] = lo ^ 8'h1A;
                            s = x.cyc + 1;
                        end else begin
                            ld = mmem[lo];
                            y.cyc = x.cyc + 1; y.reg_we = 1'b1; y.flag_we = 1'b0; y.wb_sel = 2'd1; y.ld = ld;
                            exp_st.push_back(y);
                            s = x.cyc + 2;
                        end
                    end
                endcase
            end
        end
        exp_end = s;
        exp_pc  = pc;
    endtask

    // Run n instructions from reset; stop at the first cycle of the next fetch.
    task automatic execute(input int n);
        for (int i = 0; i < 256; i++) mmem[i] = mem[i];
        model(n);
        do_reset();
        while (cyc < exp_end - 1) cycle(1'b1);
        cycle(1'b0);
    endtask

    // Counts log differences; prints detail lines for diagnosis.
    task automatic diff_logs(output int bad_tx, output int bad_st);
        int n;
        bad_tx = (act_tx.size() != exp_tx.size()) ? 1 : 0;
        bad_st = (act_st.size() != exp_st.size()) ? 1 : 0;
        n = (act_tx.size() < exp_tx.size()) ? act_tx.size() : exp_tx.size();
        for (int i = 0; i < n; i++) begin
            if (act_tx[i].cyc != exp_tx[i].cyc || act_tx[i].addr !== exp_tx[i].addr ||
                act_tx[i].we !== exp_tx[i].we || (exp_tx[i].we && act_tx[i].wdata !== exp_tx[i].wdata)) begin
                bad_tx++;
                $display("  tx[%0d] got cyc %0d addr %h we %b wd %h, want cyc %0d addr %h we %b wd %h", i,
                         act_tx[i].cyc, act_tx[i].addr, act_tx[i].we, act_tx[i].wdata,
                         exp_tx[i].cyc, exp_tx[i].addr, exp_tx[i].we, exp_tx[i].wdata);
            end
        end
        n = (act_st.size() < exp_st.size()) ? act_st.size() : exp_st.size();
        for (int i = 0; i < n; i++) begin
            if (act_st[i].cyc != exp_st[i].cyc || act_st[i].reg_we !== exp_st[i].reg_we ||
                act_st[i].flag_we !== exp_st[i].flag_we || act_st[i].wb_sel !== exp_st[i].wb_sel ||
                act_st[i].ld !== exp_st[i].ld) begin
                bad_st++;
                $display("  st[%0d] got cyc %0d rw %b fw %b sel %0d ld %h, want cyc %0d rw %b fw %b sel %0d ld %h", i,
                         act_st[i].cyc, act_st[i].reg_we, act_st[i].flag_we, act_st[i].wb_sel, act_st[i].ld,
                         exp_st[i].cyc, exp_st[i].reg_we, exp_st[i].flag_we, exp_st[i].wb_sel, exp_st[i].ld);
            end
        end
    endtask

    task automatic prep_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 512; i++) waits[i] = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc_out !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc_out, RST_PC); end
        n_tests++; if (inst_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", inst_out); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
        n_tests++; if (reg_we_out !== 1'b0) begin n_fail++; $display("FAIL reset_reg_we got %b want 0", reg_we_out); end
        n_tests++; if (flag_we_out !== 1'b0) begin n_fail++; $display("FAIL reset_flag_we got %b want 0", flag_we_out); end
        n_tests++; if (wb_sel_out !== 2'd0) begin n_fail++; $display("FAIL reset_wb_sel got %0d want 0", wb_sel_out); end
        n_tests++; if (load_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_load got %h want 00", load_data_out); end
`ifdef CPU_SEQ_STEP_EN
        n_tests++; if (halted_out !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted_out); end
`endif
    endtask

    task automatic test_alu_first();
        int bt, bs, sc;
        prep_mem();
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34;
        execute(1);
        diff_logs(bt, bs);
        sc = (act_st.size() > 0) ? act_st[0].cyc : -1;
        n_tests++; if (bt !== 0) begin n_fail++; $display("FAIL alu_tx_log got %0d diffs want 0", bt); end
        n_tests++; if (bs !== 0) begin n_fail++; $display("FAIL alu_strobe_log got %0d diffs want 0", bs); end
        n_tests++; if (act_st.size() != 1 || sc != 4) begin n_fail++; $display("FAIL alu_pulse got n=%0d cyc %0d want n=1 cyc 4", act_st.size(), sc); end
        n_tests++; if (inst_out !== 16'h1234) begin n_fail++; $display("FAIL alu_ir got %h want 1234", inst_out); end
        n_tests++; if (pc_out !== 8'h12) begin n_fail++; $display("FAIL alu_pc got %h want 12", pc_out); end
        n_tests++; if (act_tx.size() < 2 || act_tx[0].addr !== 8'h10 || act_tx[1].addr !== 8'h11) begin
            n_fail++; $display("FAIL alu_fetch_addr got n=%0d want fetches at 10,11", act_tx.size()); end
    endtask

    task automatic test_load();
        int bt, bs;
        prep_mem();
        mem[8'h10] = 8'h40; mem[8'h11] = 8'h80; mem[8'h80] = 8'hA5;
        waits[2] = 3;
        execute(1);
        diff_logs(bt, bs);
        n_tests++; if (bt !== 0 || bs !== 0) begin n_fail++; $display("FAIL load_logs got %0d/%0d diffs want 0/0", bt, bs); end
        n_tests++; if (act_tx.size() < 3 || act_tx[2].cyc != 7 || act_tx[2].addr !== 8'h80) begin
            n_fail++; $display("FAIL load_req_hold got n=%0d want ack of addr 80 at cycle 7", act_tx.size()); end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL load_stable got %0d changes want 0", unstable); end
        n_tests++; if (load_data_out !== 8'hA5) begin n_fail++; $display("FAIL load_data got %h want A5", load_data_out); end
        n_tests++; if (act_st.size() != 1 || act_st[0].wb_sel !== 2'd1) begin
            n_fail++; $display("FAIL load_wb got n=%0d want one pulse sel 1", act_st.size()); end
    endtask

    task automatic test_store();
        int bt, bs;
        prep_mem();
        mem[8'h10] = 8'h41; mem[8'h11] = 8'h40;
        execute(1);
        diff_logs(bt, bs);
        n_tests++; if (bt !== 0 || bs !== 0) begin n_fail++; $display("FAIL store_logs got %0d/%0d diffs want 0/0", bt, bs); end
        n_tests++; if (act_tx.size() != 3 || act_tx[2].we !== 1'b1 || act_tx[2].wdata !== 8'h5A || act_tx[2].addr !== 8'h40) begin
            n_fail++; $display("FAIL store_xfer got n=%0d want one write of 5A at 40", act_tx.size()); end
        n_tests++; if (act_st.size() != 0) begin n_fail++; $display("FAIL store_no_wb got %0d strobes want 0", act_st.size()); end
        n_tests++; if (mem[8'h40] !== 8'h5A) begin n_fail++; $display("FAIL store_mem got %h want 5A", mem[8'h40]); end
    endtask

    task automatic test_cond_jump();
        int bt, bs;
        prep_mem();
        mem[8'h10] = 8'hA0; mem[8'h11] = 8'h03;
        mem[8'h12] = 8'hB0; mem[8'h13] = 8'h03;
        mem[8'h03] = 8'h00; mem[8'h04] = 8'h01;
        execute(3);
        diff_logs(bt, bs);
        n_tests++; if (bt !== 0 || bs !== 0) begin n_fail++; $display("FAIL cjump_logs got %0d/%0d diffs want 0/0", bt, bs); end
        n_tests++; if (act_tx.size() < 3 || act_tx[2].addr !== 8'h12) begin n_fail++; $display("FAIL cjump_skip got n=%0d want fetch at 12", act_tx.size()); end
        n_tests++; if (act_tx.size() < 5 || act_tx[4].addr !== 8'h03) begin n_fail++; $display("FAIL cjump_taken got n=%0d want fetch at 03", act_tx.size()); end
        n_tests++; if (pc_out !== 8'h05) begin n_fail++; $display("FAIL cjump_pc got %h want 05", pc_out); end
    endtask

    task automatic test_pc_wrap();
        int bt, bs;
        prep_mem();
        mem[8'h10] = 8'h80; mem[8'h11] = 8'hFE;
        mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h00;
        execute(2);
        diff_logs(bt, bs);
        n_tests++; if (bt !== 0 || bs !== 0) begin n_fail++; $display("FAIL wrap_logs got %0d/%0d diffs want 0/0", bt, bs); end
        n_tests++; if (act_tx.size() < 4 || act_tx[3].addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_lo_addr got n=%0d want fetch at FF", act_tx.size()); end
        n_tests++; if (pc_out !== 8'h00) begin n_fail++; $display("FAIL wrap_pc got %h want 00", pc_out); end
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_next got req %b addr %h want 1 00", mem_req, mem_addr); end
    endtask

    task automatic test_reset_abort();
        prep_mem();
        mem[8'h10] = 8'h40; mem[8'h11] = 8'h80;
        waits[2] = 50;
        do_reset();
        while (cyc < 5) cycle(1'b1);
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 8'h80) begin n_fail++; $display("FAIL abort_wait got req %b addr %h want 1 80", mem_req, mem_addr); end
        rst_n = 1'b0;
        cycle(1'b0);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_req got %b want 0", mem_req); end
        rst_n = 1'b1;
        cycle(1'b0);
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin n_fail++; $display("FAIL abort_refetch got req %b addr %h want 1 %h", mem_req, mem_addr, RST_PC); end
        n_tests++; if (pc_out !== RST_PC) begin n_fail++; $display("FAIL abort_pc got %h want %h", pc_out, RST_PC); end
    endtask

    task automatic test_random();
        int bt, bs;
        for (int r = 0; r < 8; r++) begin
            prep_mem();
            for (int i = 0; i < 512; i++)
                waits[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            execute(10);
            diff_logs(bt, bs);
            n_tests++; if (bt !== 0) begin n_fail++; $display("FAIL rand%0d_tx got %0d diffs want 0", r, bt); end
            n_tests++; if (bs !== 0) begin n_fail++; $display("FAIL rand%0d_strobe got %0d diffs want 0", r, bs); end
            n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL rand%0d_stable got %0d changes want 0", r, unstable); end
            n_tests++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL rand%0d_pc got %h want %h", r, pc_out, exp_pc); end
            n_tests++; if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin n_fail++; $display("FAIL rand%0d_next got req %b addr %h want 1 %h", r, mem_req, mem_addr, exp_pc); end
        end
    endtask

`ifdef CPU_SEQ_STEP_EN
    task automatic test_step();
        int bad;
        prep_mem();
        for (int i = 8'h10; i < 8'h16; i++) mem[i] = 8'h00;
        step_in = 1'b0;
        do_reset();
        while (cyc < 4) cycle(1'b1);
        n_tests++; if (act_st.size() != 1) begin n_fail++; $display("FAIL step_first got %0d strobes want 1", act_st.size()); end
        bad = 0;
        repeat (10) begin
            cycle(1'b1);
            if (halted_out !== 1'b1 || mem_req !== 1'b0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL step_halt got %0d bad cycles want 0", bad); end
        step_in = 1'b1;
        cycle(1'b1);
        step_in = 1'b0;
        repeat (8) cycle(1'b1);
        n_tests++; if (act_st.size() != 2 || act_tx.size() != 4) begin
            n_fail++; $display("FAIL step_one got %0d strobes %0d xfers want 2 4", act_st.size(), act_tx.size()); end
        n_tests++; if (act_tx.size() < 3 || act_tx[2].addr !== 8'h12) begin n_fail++; $display("FAIL step_addr got n=%0d want fetch at 12", act_tx.size()); end
        n_tests++; if (halted_out !== 1'b1) begin n_fail++; $display("FAIL step_rehalt got %b want 1", halted_out); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
`ifdef CPU_SEQ_STEP_EN
        test_step();
`else
        test_alu_first();
        test_load();
        test_store();
        test_cond_jump();
        test_pc_wrap();
        test_reset_abort();
        test_random();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the tiny CPU core.
- Fetches each 16-bit instruction as two bytes over a shared 8-bit memory handshake port and holds it in the instruction register that drives the instruction decoder.
- Consumes the decoded fields and sequences execute, memory-access and write-back, including conditional skip and jumps.
- Sits between the external memory interface and the register file / ALU.

Parameters:
- ADDR_W, 8, width of the memory address and program counter.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  transfer address
- mem_wdata  out  8  store data
- mem_rdata  in  8  read data, valid when mem_ack=1
- mem_ack  in  1  transfer complete
- inst_out  out  16  instruction register, to decoder
- inst_type_in  in  2  decoded type: 0 ALU, 1 MEM, 2 JUMP, 3 IMM
- cond_en_in  in  1  decoded conditional-execute bit
- subtype_in  in  4  decoded subtype; bit0 = 1 means store (MEM type)
- cond_flag_in  in  1  current condition flag from ALU flags
- data_addr_in  in  ADDR_W  load/store address from register file
- store_data_in  in  8  store data from register file
- jump_target_in  in  ADDR_W  jump destination
- reg_we_out  out  1  register-file write strobe, one cycle
- flag_we_out  out  1  flag-register write strobe, one cycle
- wb_sel_out  out  2  write-back source: 0 ALU, 1 load data, 2 immediate
- load_data_out  out  8  latched load byte
- pc_out  out  ADDR_W  current PC

Behaviour:
- States: IDLE, FETCH_HI, FETCH_LO, DECODE, EXEC, MEM, WB.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; PC=RESET_PC; IR=16'h0000; load_data_out=0; wb_sel_out=0.
  - mem_req, mem_we, reg_we_out and flag_we_out are all 0.
  - Reset aborts any outstanding transfer. mem_req is 0 in the first cycle after the reset edge.
- IDLE -> FETCH_HI unconditionally on the next edge with rst_n=1.
- Handshake:
  - mem_req is a Moore output, 1 only in FETCH_HI, FETCH_LO and MEM.
  - A transfer completes on each rising edge with mem_req=1 and mem_ack=1.
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and no ack has arrived.
  - mem_ack while mem_req=0 is ignored.
  - Wait states are unlimited.
- FETCH_HI: mem_addr=PC, mem_we=0. On ack, IR[15:8]<=mem_rdata and go to FETCH_LO.
- FETCH_LO: mem_addr=PC+1 (mod 2^ADDR_W), mem_we=0. On ack, IR[7:0]<=mem_rdata, PC<=PC+2 (wraps mod 2^ADDR_W), go to DECODE.
- inst_out=IR at all times. IR[15:8] updates before IR[7:0]. Decoded inputs are valid only in DECODE and later states.
- DECODE:
  - If cond_en_in=1 and cond_flag_in=0, the instruction is skipped: go to FETCH_HI with no strobes and no PC change.
  - Otherwise ALU, IMM and JUMP go to EXEC; MEM goes to MEM.
- EXEC (1 cycle), then FETCH_HI:
  - ALU: reg_we_out=1, flag_we_out=1, wb_sel_out=0.
  - IMM: reg_we_out=1, wb_sel_out=2; flags untouched.
  - JUMP: PC<=jump_target_in; no strobes.
- MEM:
  - mem_addr=data_addr_in; mem_we=subtype_in[0]; mem_wdata=store_data_in.
  - On ack: a store goes to FETCH_HI; a load latches load_data_out<=mem_rdata and goes to WB.
- WB: reg_we_out=1, wb_sel_out=1, one cycle, then FETCH_HI.
- wb_sel_out holds its last value outside strobe cycles.
- Zero-wait latency in cycles: ALU, IMM and JUMP 4; store 4; load 5; skipped instruction 3.

Optional Feature:
- Macro CPU_SEQ_STEP_EN.
- When defined:
  - Adds input step_in (1 bit) and output halted_out (1 bit).
  - Every path that would enter FETCH_HI from DECODE, EXEC, MEM or WB enters a HALT state instead.
  - In HALT: halted_out=1, mem_req=0. A rising step_in (0->1, sampled on clk) moves to FETCH_HI.
  - IDLE -> FETCH_HI after reset is unaffected, so the first instruction runs freely.
  - Reset forces halted_out=0.
- When undefined: no HALT state, no step_in/halted_out ports, behaviour exactly as above.

Test Plan:
- Reset with RESET_PC=8'h10, zero-wait memory returning 8'h12 then 8'h34, ALU type -> fetches from 8'h10 and 8'h11, inst_out=16'h1234, reg_we_out and flag_we_out pulse once at cycle 4, pc_out=8'h12.
- Load, data_addr_in=8'h80, memory returns 8'hA5 after 3 wait cycles -> mem_req held 4 cycles with stable address, load_data_out=8'hA5, one reg_we_out pulse with wb_sel_out=1.
- Store, store_data_in=8'h5A, data_addr_in=8'h40 -> one transfer with mem_we=1, mem_wdata=8'h5A, no reg_we_out.
- Conditional JUMP, cond_en=1 and cond_flag=0 -> no PC load, next fetch at PC+2; repeat with cond_flag=1 and target=8'h03 -> next fetch at 8'h03.
- PC=8'hFE fetch -> second byte read from 8'hFF, then PC=8'h00; rst_n=0 during a MEM wait state -> mem_req=0 the next cycle, then refetch from RESET_PC.
- CPU_SEQ_STEP_EN: after the first instruction, halted_out=1 and mem_req=0 for 10 cycles; a step_in pulse -> exactly one instruction executes, then HALT again.
